// File: rtl/fc_pkg.sv
// Shared types and fixed-point helpers for the fully-connected layer sequencer.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } fc_state_t;

    // Index width for a table of v entries; never narrower than one bit.
    function automatic int addr_w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Full-width signed product shifted down by the fractional bit count.
    // Operands arrive sign-extended to 32 bits; the caller keeps the low SIZE bits.
    function automatic logic signed [63:0] fx_mul(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 precision
    );
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        ax = 64'(a);
        bx = 64'(b);
        return (ax * bx) >>> precision;
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Multiply-truncate-add step: acc_out = acc_in + trunc((weight * x) >>> PRECISION),
// wrapping modulo 2^SIZE.
module fc_mac
    import fc_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int PRECISION = 11
) (
    input  logic [SIZE-1:0] acc_in,
    input  logic [SIZE-1:0] weight,
    input  logic [SIZE-1:0] x,
    output logic [SIZE-1:0] acc_out
);

    logic signed [63:0] prod;

    always_comb begin
        prod    = fx_mul(32'(signed'(weight)), 32'(signed'(x)), PRECISION);
        acc_out = acc_in + prod[SIZE-1:0];
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer: per neuron, bias plus IN_SZ weighted inputs,
// emitted over a valid/ready channel. Define FC_RELU_EN to clamp negative results to zero.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int PRECISION = 11,
    parameter int IN_SZ     = 2,
    parameter int OUT_SZ    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              in_ready,
    input  logic [IN_SZ*SIZE-1:0]             inputs,
    output logic [addr_w(OUT_SZ*IN_SZ)-1:0]   weight_addr,
    input  logic [SIZE-1:0]                   weight_data,
    output logic [addr_w(OUT_SZ)-1:0]         bias_addr,
    input  logic [SIZE-1:0]                   bias_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [addr_w(OUT_SZ)-1:0]         out_idx,
    output logic [SIZE-1:0]                   out_value,
    output logic                              done
);

    localparam int WAW = addr_w(OUT_SZ * IN_SZ);
    localparam int NW  = addr_w(OUT_SZ);
    localparam int KW  = addr_w(IN_SZ);

    localparam logic [NW-1:0] N_LAST = NW'(OUT_SZ - 1);
    localparam logic [KW-1:0] K_LAST = KW'(IN_SZ - 1);

    fc_state_t                  state, state_next;
    logic [NW-1:0]              n, n_next;
    logic [KW-1:0]              k, k_next;
    logic [SIZE-1:0]            acc, acc_next, mac_out;
    logic [IN_SZ-1:0][SIZE-1:0] x_reg;
    logic                       load_x;

    fc_mac #(
        .SIZE      (SIZE),
        .PRECISION (PRECISION)
    ) u_mac (
        .acc_in  (acc),
        .weight  (weight_data),
        .x       (x_reg[k]),
        .acc_out (mac_out)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_next = state;
        n_next     = n;
        k_next     = k;
        acc_next   = acc;
        load_x     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load_x     = 1'b1;
                    n_next     = '0;
                    k_next     = '0;
                    acc_next   = bias_data;
                    state_next = MAC;
                end
            end
            MAC: begin
                acc_next = mac_out;
                if (k == K_LAST) begin
                    k_next     = '0;
                    state_next = EMIT;
                end else begin
                    k_next = k + 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (n == N_LAST) begin
                        n_next     = '0;
                        state_next = DONE;
                    end else begin
                        n_next     = n + 1'b1;
                        k_next     = '0;
                        acc_next   = bias_data;
                        state_next = MAC;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            n     <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            state <= state_next;
            n     <= n_next;
            k     <= k_next;
            acc   <= acc_next;
        end
    end

    // NOTE: the input latch has no reset; it is only read after a load on acceptance.
    always_ff @(posedge clk) begin
        if (load_x) begin
            x_reg <= inputs;
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == EMIT);
    assign done        = (state == DONE);
    assign out_idx     = n;
    assign weight_addr = WAW'(n) * WAW'(IN_SZ) + WAW'(k);
    // In EMIT the bias port looks ahead so the next neuron starts from its bias on the handshake.
    assign bias_addr   = (state == EMIT && n != N_LAST) ? n + 1'b1 : n;

`ifdef FC_RELU_EN
    assign out_value = acc[SIZE-1] ? '0 : acc;
`else
    assign out_value = acc;
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer: directed vectors, stall, ignored start,
// mid-layer reset and randomized layers against an arithmetic reference model.
module tb_fc_layer_sequencer;

    localparam int SIZE   = 16;
    localparam int PREC   = 11;
    localparam int IN_SZ  = 2;
    localparam int OUT_SZ = 2;
    localparam int LAT    = IN_SZ + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  out_ready = 1'b0;
    logic                  in_ready, out_valid, done;
    logic [IN_SZ*SIZE-1:0] inputs = '0;
    logic [1:0]            weight_addr;
    logic [0:0]            bias_addr, out_idx;
    logic [SIZE-1:0]       weight_data, bias_data, out_value;

    logic [SIZE-1:0] w_mem [OUT_SZ*IN_SZ];
    logic [SIZE-1:0] b_mem [OUT_SZ];

    assign weight_data = w_mem[weight_addr];
    assign bias_data   = b_mem[bias_addr];

    int tests_run = 0;
    int failed    = 0;

    logic [SIZE-1:0] got_val [OUT_SZ];
    logic [0:0]      got_idx [OUT_SZ];
    int              got_lat [OUT_SZ];
    logic            got_done, got_done_after, got_ready_after;
    logic            ready_leak, stall_stable, timed_out;

    fc_layer_sequencer #(
        .SIZE      (SIZE),
        .PRECISION (PREC),
        .IN_SZ     (IN_SZ),
        .OUT_SZ    (OUT_SZ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_ready    (in_ready),
        .inputs      (inputs),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .bias_addr   (bias_addr),
        .bias_data   (bias_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_value   (out_value),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference: bias + sum of fixed-point products, each truncated to SIZE bits, wrapping.
    function automatic logic [SIZE-1:0] model(input int nn, input logic [IN_SZ*SIZE-1:0] xv);
        logic [SIZE-1:0]    acc;
        logic [SIZE-1:0]    xs;
        logic signed [31:0] p;
        acc = b_mem[nn];
        for (int kk = 0; kk < IN_SZ; kk++) begin
            xs  = xv[kk*SIZE +: SIZE];
            p   = 32'($signed(w_mem[nn*IN_SZ + kk])) * 32'($signed(xs));
            p   = p >>> PREC;
            acc = acc + p[SIZE-1:0];
        end
`ifdef FC_RELU_EN
        if (acc[SIZE-1]) acc = '0;
`endif
        return acc;
    endfunction

    task automatic randomize_mems();
        for (int i = 0; i < OUT_SZ*IN_SZ; i++) w_mem[i] = SIZE'($urandom);
        for (int i = 0; i < OUT_SZ; i++) b_mem[i] = SIZE'($urandom);
    endtask

    // Runs one layer from IDLE; entered and left #1 after a rising edge.
    task automatic run_layer(input logic [IN_SZ*SIZE-1:0] xv, input int stall0, input logic poke);
        int cnt;
        timed_out    = 1'b0;
        ready_leak   = 1'b0;
        stall_stable = 1'b1;
        inputs    = xv;
        start     = 1'b1;
        out_ready = (stall0 == 0);
        @(posedge clk); #1;
        start  = poke;
        inputs = $urandom;
        for (int i = 0; i < OUT_SZ; i++) begin
            cnt = 1;
            while (!out_valid && cnt < 40) begin
                if (in_ready) ready_leak = 1'b1;
                @(posedge clk); #1;
                cnt++;
            end
            if (!out_valid) timed_out = 1'b1;
            if (in_ready) ready_leak = 1'b1;
            got_lat[i] = cnt;
            got_val[i] = out_value;
            got_idx[i] = out_idx;
            if (i == 0 && stall0 > 0) begin
                repeat (stall0) begin
                    @(posedge clk); #1;
                    if (!out_valid || out_value !== got_val[0] || out_idx !== 1'b0) stall_stable = 1'b0;
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        got_done = done;
        if (in_ready) ready_leak = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        got_done_after  = done;
        got_ready_after = in_ready;
    endtask

    task automatic test_reset();
        tests_run++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got=%b exp=0", done); end
        tests_run++; if (out_value !== '0) begin failed++; $display("FAIL reset_out_value got=%h exp=0", out_value); end
        tests_run++; if (out_idx !== '0) begin failed++; $display("FAIL reset_out_idx got=%h exp=0", out_idx); end
        tests_run++; if (weight_addr !== '0) begin failed++; $display("FAIL reset_weight_addr got=%h exp=0", weight_addr); end
        tests_run++; if (bias_addr !== '0) begin failed++; $display("FAIL reset_bias_addr got=%h exp=0", bias_addr); end
    endtask

    task automatic test_directed();
        logic [SIZE-1:0]       w0 [3], w1 [3], bb [3], ex [3];
        logic [IN_SZ*SIZE-1:0] xv [3];
        logic [SIZE-1:0]       e1;
        w0[0] = 16'h0800; w1[0] = 16'h0800; xv[0] = {16'h0800, 16'h0800}; bb[0] = 16'h0800; ex[0] = 16'h1800;
        w0[1] = 16'h0800; w1[1] = 16'h0400; xv[1] = {16'h2000, 16'h1800}; bb[1] = 16'h0C00; ex[1] = 16'h3400;
        w0[2] = 16'h0800; w1[2] = 16'h0800; xv[2] = {16'hF000, 16'hF800}; bb[2] = 16'h0000;
`ifdef FC_RELU_EN
        ex[2] = 16'h0000;
`else
        ex[2] = 16'hE800;
`endif
        for (int v = 0; v < 3; v++) begin
            randomize_mems();
            w_mem[0] = w0[v];
            w_mem[1] = w1[v];
            b_mem[0] = bb[v];
            e1 = model(1, xv[v]);
            run_layer(xv[v], 0, 1'b0);
            tests_run++; if (timed_out) begin failed++; $display("FAIL directed%0d_timeout no out_valid within budget", v); end
            tests_run++; if (got_val[0] !== ex[v]) begin failed++; $display("FAIL directed%0d_value got=%h exp=%h", v, got_val[0], ex[v]); end
            tests_run++; if (got_val[1] !== e1) begin failed++; $display("FAIL directed%0d_value1 got=%h exp=%h", v, got_val[1], e1); end
            tests_run++; if (got_lat[0] != LAT) begin failed++; $display("FAIL directed%0d_latency got=%0d exp=%0d", v, got_lat[0], LAT); end
            tests_run++; if (got_done !== 1'b1) begin failed++; $display("FAIL directed%0d_done got=%b exp=1", v, got_done); end
            tests_run++; if (got_done_after !== 1'b0) begin failed++; $display("FAIL directed%0d_done_pulse got=%b exp=0", v, got_done_after); end
        end
    endtask

    task automatic test_stall();
        logic [IN_SZ*SIZE-1:0] xv;
        randomize_mems();
        xv = {SIZE'($urandom), SIZE'($urandom)};
        run_layer(xv, 5, 1'b0);
        tests_run++; if (stall_stable !== 1'b1) begin failed++; $display("FAIL stall_stable got=%b exp=1", stall_stable); end
        tests_run++; if (got_idx[0] !== 1'b0) begin failed++; $display("FAIL stall_idx0 got=%h exp=0", got_idx[0]); end
        tests_run++; if (got_idx[1] !== 1'b1) begin failed++; $display("FAIL stall_idx1 got=%h exp=1", got_idx[1]); end
        tests_run++; if (got_lat[1] != LAT) begin failed++; $display("FAIL stall_latency1 got=%0d exp=%0d", got_lat[1], LAT); end
        tests_run++; if (got_val[0] !== model(0, xv)) begin failed++; $display("FAIL stall_value0 got=%h exp=%h", got_val[0], model(0, xv)); end
        tests_run++; if (got_val[1] !== model(1, xv)) begin failed++; $display("FAIL stall_value1 got=%h exp=%h", got_val[1], model(1, xv)); end
    endtask

    task automatic test_start_ignored();
        logic [IN_SZ*SIZE-1:0] xv;
        randomize_mems();
        xv = {SIZE'($urandom), SIZE'($urandom)};
        run_layer(xv, 0, 1'b1);
        tests_run++; if (ready_leak !== 1'b0) begin failed++; $display("FAIL busy_in_ready got=%b exp=0", ready_leak); end
        tests_run++; if (got_val[0] !== model(0, xv)) begin failed++; $display("FAIL busy_value0 got=%h exp=%h", got_val[0], model(0, xv)); end
        tests_run++; if (got_val[1] !== model(1, xv)) begin failed++; $display("FAIL busy_value1 got=%h exp=%h", got_val[1], model(1, xv)); end
        tests_run++; if (got_ready_after !== 1'b1) begin failed++; $display("FAIL busy_ready_after got=%b exp=1", got_ready_after); end
    endtask

    task automatic test_reset_midway();
        logic [IN_SZ*SIZE-1:0] xv;
        logic                  seen;
        int                    cnt;
        randomize_mems();
        xv = {SIZE'($urandom), SIZE'($urandom)};
        inputs    = xv;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        tests_run++; if (!out_valid) begin failed++; $display("FAIL midrst_first_valid got=0 exp=1"); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin failed++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL midrst_done got=%b exp=0", done); end
        tests_run++; if (out_value !== '0) begin failed++; $display("FAIL midrst_out_value got=%h exp=0", out_value); end
        tests_run++; if (out_idx !== '0) begin failed++; $display("FAIL midrst_out_idx got=%h exp=0", out_idx); end
        tests_run++; if (weight_addr !== '0) begin failed++; $display("FAIL midrst_weight_addr got=%h exp=0", weight_addr); end
        tests_run++; if (bias_addr !== '0) begin failed++; $display("FAIL midrst_bias_addr got=%h exp=0", bias_addr); end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid || done) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin failed++; $display("FAIL midrst_abandon got=%b exp=0", seen); end
        tests_run++; if (in_ready !== 1'b1) begin failed++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        xv = {SIZE'($urandom), SIZE'($urandom)};
        run_layer(xv, 0, 1'b0);
        tests_run++; if (got_val[0] !== model(0, xv)) begin failed++; $display("FAIL midrst_fresh0 got=%h exp=%h", got_val[0], model(0, xv)); end
        tests_run++; if (got_val[1] !== model(1, xv)) begin failed++; $display("FAIL midrst_fresh1 got=%h exp=%h", got_val[1], model(1, xv)); end
        tests_run++; if (got_done !== 1'b1) begin failed++; $display("FAIL midrst_fresh_done got=%b exp=1", got_done); end
    endtask

    task automatic test_random();
        logic [IN_SZ*SIZE-1:0] xv;
        int                    stall;
        for (int it = 0; it < 25; it++) begin
            randomize_mems();
            xv    = {SIZE'($urandom), SIZE'($urandom)};
            stall = int'($urandom_range(0, 3));
            run_layer(xv, stall, 1'(it % 2));
            tests_run++; if (timed_out) begin failed++; $display("FAIL rand%0d_timeout no out_valid within budget", it); end
            for (int i = 0; i < OUT_SZ; i++) begin
                tests_run++; if (got_val[i] !== model(i, xv)) begin failed++; $display("FAIL rand%0d_value%0d got=%h exp=%h", it, i, got_val[i], model(i, xv)); end
                tests_run++; if (got_idx[i] !== 1'(i)) begin failed++; $display("FAIL rand%0d_idx%0d got=%h exp=%0d", it, i, got_idx[i], i); end
            end
            tests_run++; if (got_lat[OUT_SZ-1] != LAT) begin failed++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, got_lat[OUT_SZ-1], LAT); end
            tests_run++; if (got_done !== 1'b1 || got_done_after !== 1'b0) begin failed++; $display("FAIL rand%0d_done got=%b%b exp=10", it, got_done, got_done_after); end
        end
    endtask

    initial begin
        randomize_mems();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_stall();
        test_start_ignored();
        test_reset_midway();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/fc_layer_sequencer.md
FC_LAYER_SEQUENCER -- requirements
Module: fc_layer_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 16, fixed-point word width in bits (signed two's complement).
REQ-002 SHALL have parameter PRECISION, default 11, fractional bits per word.
REQ-003 SHALL have parameter IN_SZ, default 2, inputs per neuron (>=1).
REQ-004 SHALL have parameter OUT_SZ, default 2, neurons per layer (>=1).
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  in  1  request to evaluate one layer.
REQ-008 SHALL have port in_ready  out  1  high only in IDLE; start accepted when start & in_ready.
REQ-009 SHALL have port inputs  in  IN_SZ x SIZE  packed input vector, index 0 first; sampled on acceptance.
REQ-010 SHALL have port weight_addr  out  clog2(OUT_SZ*IN_SZ)  = n*IN_SZ + k.
REQ-011 SHALL have port weight_data  in  SIZE  weight at weight_addr, combinational read, same cycle.
REQ-012 SHALL have port bias_addr  out  clog2(OUT_SZ) (min 1)  current neuron index n.
REQ-013 SHALL have port bias_data  in  SIZE  bias at bias_addr, combinational read.
REQ-014 SHALL have ports out_valid  out  1, out_ready  in  1, out_idx  out  clog2(OUT_SZ) (min 1), out_value  out  SIZE  per-neuron result channel.
REQ-015 SHALL have port done  out  1  one-cycle pulse after last neuron accepted.

Function
REQ-016 SHALL implement states IDLE, MAC, EMIT, DONE.
REQ-017 SHALL, in IDLE on start & in_ready, latch inputs, set n=0, k=0, acc=bias_data (at n=0), go to MAC.
REQ-018 SHALL, each MAC cycle, update acc = acc + trunc((weight_data * inputs[k]) >>> PRECISION), k++; after k=IN_SZ-1 go to EMIT.
REQ-019 SHALL compute product as full 2*SIZE signed, arithmetic shift right PRECISION, keep low SIZE bits; accumulation wraps modulo 2^SIZE (no saturation).
REQ-020 SHALL, in EMIT, drive out_valid=1, out_idx=n, out_value=acc stable until out_ready; on out_valid & out_ready: if n<OUT_SZ-1 then n++, k=0, acc=bias_data of n+1, go to MAC; else go to DONE.
REQ-021 SHALL pulse done=1 for exactly the DONE cycle, then return to IDLE.
REQ-022 SHALL give latency IN_SZ+1 cycles from acceptance to first out_valid, and IN_SZ+1 cycles between successive out_valid assertions with out_ready held high.
REQ-023 SHALL ignore start outside IDLE; inputs changes after acceptance SHALL NOT affect results.
REQ-024 SHALL hold out_valid low outside EMIT; out_ready outside EMIT SHALL have no effect.

Reset
REQ-025 SHALL on rst force IDLE, n=0, k=0, acc=0, out_valid=0, done=0, out_value=0, out_idx=0, weight_addr=0, bias_addr=0, in_ready=1 after release.
REQ-026 SHALL abandon any in-flight layer on rst mid-operation; no out_valid or done for it afterwards.

Configuration
REQ-027 SHALL, with FC_RELU_EN defined, drive out_value = 0 when acc is negative (sign bit set), else acc; without it, out_value = acc unmodified.

Structure
REQ-028 SHALL place the state enum and a fixed-point multiply function (SIZE, PRECISION parameterised) in package fc_pkg.
REQ-029 SHALL isolate the multiply-truncate-add datapath in sub-module fc_mac; the FSM and counters stay in fc_layer_sequencer.

Verification
REQ-030 Single neuron (IN_SZ=2, OUT_SZ=1): w={h800,h800}, x={h800,h800}, b=h800 -> out_value=h1800 three cycles after acceptance, then done pulse.
REQ-031 w={h800,h400}, x={h1800,h2000}, b=hC00 -> out_value=h3400.
REQ-032 OUT_SZ=2, out_ready held low 5 cycles in first EMIT -> out_valid/out_idx=0/out_value stable throughout; second neuron out_idx=1 follows IN_SZ+1 cycles after handshake.
REQ-033 start pulsed during MAC with different inputs -> ignored; results match first vector; in_ready=0 until after done.
REQ-034 rst asserted during second neuron's MAC -> all outputs zero immediately; no done; fresh start then yields correct results.
REQ-035 w={h800,h800}, x={hF800,hF000} (-1.0,-2.0), b=h0 -> out_value=hE800 without FC_RELU_EN, h0000 with it.
